// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding, key constants and widths for the digital lock.
package lock_pkg;
    localparam int DIGIT_W = 4;
    localparam int LEN_W   = 3;

    typedef enum logic [2:0] {
        LOCKED       = 3'd0,
        ENTRY        = 3'd1,
        UNLOCKED     = 3'd2,
        PROG_NEW     = 3'd3,
        PROG_CONFIRM = 3'd4,
        LOCKOUT      = 3'd5
    } state_e;

    localparam logic [3:0] KEY_MAX_DIGIT = 4'd6;
    localparam logic [3:0] KEY_CLEAR     = 4'd7;
    localparam logic [3:0] KEY_PROG      = 4'd8;
    localparam logic [3:0] KEY_ENTER     = 4'd9;
endpackage

// File: rtl/code_buffer.sv
// code_buffer: digit slots with saturating length and overflow flag; clear and append may coincide.
module code_buffer
    import lock_pkg::*;
#(
    parameter int MAX_LEN = 6
) (
    input  logic                             hwclk,
    input  logic                             rst_n,
    input  logic                             clear_i,
    input  logic                             append_i,
    input  logic [DIGIT_W-1:0]               digit_i,
    output logic [MAX_LEN-1:0][DIGIT_W-1:0]  digits_o,
    output logic [LEN_W-1:0]                 len_o,
    output logic                             ovf_o
);
    logic [MAX_LEN-1:0][DIGIT_W-1:0] slots_q, slots_d;
    logic [LEN_W-1:0]                len_q, len_d, base;
    logic                            ovf_q, ovf_d;

    // A clear in the same cycle as an append makes the new digit land in slot 0.
    always_comb begin
        slots_d = clear_i ? '0 : slots_q;
        base    = clear_i ? '0 : len_q;
        ovf_d   = clear_i ? 1'b0 : ovf_q;
        len_d   = base;
        if (append_i) begin
            for (int i = 0; i < MAX_LEN; i++)
                if (base == LEN_W'(i)) slots_d[i] = digit_i;
            ovf_d = (base >= LEN_W'(MAX_LEN)) ? 1'b1 : ovf_d;
            len_d = (base > LEN_W'(MAX_LEN)) ? base : base + 1'b1;
        end
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            slots_q <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            slots_q <= slots_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    assign digits_o = slots_q;
    assign len_o    = len_q;
    assign ovf_o    = ovf_q;
endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer: keypad code lock controller owning entry, unlock, reprogram and lockout modes.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int MIN_LEN     = 4,
    parameter int MAX_LEN     = 6,
    parameter int MAX_TRIES   = 3,
    parameter int LOCKOUT_CYC = 1000,
    parameter int DEFAULT_LEN = 4
) (
    input  logic       hwclk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       locked,
    output logic       prog_mode,
    output logic       lockout,
    output logic       ok_pulse,
    output logic       err_pulse,
    output logic [2:0] entry_len,
    output logic [2:0] state_dbg
);
    localparam int TMR_W  = $clog2(LOCKOUT_CYC + 1);
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);

    typedef logic [MAX_LEN-1:0][DIGIT_W-1:0] code_t;

    function automatic code_t default_code();
        code_t c = '0;
        for (int i = 0; i < DEFAULT_LEN; i++) c[i] = DIGIT_W'(i + 1);
        return c;
    endfunction

    localparam code_t DEF_CODE = default_code();

    state_e            state_q, state_d;
    logic [FAIL_W-1:0] fail_q, fail_d, fail_inc;
    logic [TMR_W-1:0]  timer_q, timer_d;
    code_t             code_q, code_d, stage_q, stage_d, digits;
    logic [LEN_W-1:0]  code_len_q, code_len_d, stage_len_q, stage_len_d, len;
    logic              ok_q, ok_d, err_q, err_d;
    logic              ovf, clr, app, code_eq, stage_eq, len_ok;
    logic              is_dig, is_clr, is_prog, is_ent;

    code_buffer #(.MAX_LEN(MAX_LEN)) u_entry (
        .hwclk    (hwclk),
        .rst_n    (rst_n),
        .clear_i  (clr),
        .append_i (app),
        .digit_i  (key_code),
        .digits_o (digits),
        .len_o    (len),
        .ovf_o    (ovf)
    );

    assign is_dig   = key_valid && key_code <= KEY_MAX_DIGIT;
    assign is_clr   = key_valid && key_code == KEY_CLEAR;
    assign is_prog  = key_valid && key_code == KEY_PROG;
    assign is_ent   = key_valid && key_code == KEY_ENTER;
    assign fail_inc = fail_q + 1'b1;
    assign len_ok   = !ovf && len >= LEN_W'(MIN_LEN) && len <= LEN_W'(MAX_LEN);

    always_comb begin
        code_eq  = !ovf && len == code_len_q;
        stage_eq = !ovf && len == stage_len_q;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < len && digits[i] != code_q[i])  code_eq  = 1'b0;
            if (LEN_W'(i) < len && digits[i] != stage_q[i]) stage_eq = 1'b0;
        end
    end

    // Every exit from a collecting state clears the buffer, so entry_len reads 0 outside an entry.
    always_comb begin
        state_d     = state_q;
        fail_d      = fail_q;
        timer_d     = timer_q;
        code_d      = code_q;
        code_len_d  = code_len_q;
        stage_d     = stage_q;
        stage_len_d = stage_len_q;
        ok_d        = 1'b0;
        err_d       = 1'b0;
        clr         = 1'b0;
        app         = 1'b0;
        case (state_q)
            LOCKED: if (is_dig) begin
                clr     = 1'b1;
                app     = 1'b1;
                state_d = ENTRY;
            end
            ENTRY: begin
                app = is_dig;
                clr = is_clr || is_ent;
                if (is_clr) state_d = LOCKED;
                if (is_ent && code_eq) begin
                    state_d = UNLOCKED;
                    ok_d    = 1'b1;
                    fail_d  = '0;
                end else if (is_ent) begin
                    err_d   = 1'b1;
                    fail_d  = fail_inc;
                    timer_d = TMR_W'(LOCKOUT_CYC - 1);
                    state_d = (fail_inc == FAIL_W'(MAX_TRIES)) ? LOCKOUT : LOCKED;
                end
            end
            UNLOCKED: begin
                clr = is_prog;
                state_d = is_ent ? LOCKED : is_prog ? PROG_NEW : state_q;
            end
            PROG_NEW: begin
                app = is_dig;
                clr = is_clr || is_prog;
                if (is_clr) state_d = UNLOCKED;
                if (is_prog && len_ok) begin
                    stage_d     = digits;
                    stage_len_d = len;
                    state_d     = PROG_CONFIRM;
                end else if (is_prog) begin
                    err_d   = 1'b1;
                    state_d = UNLOCKED;
                end
            end
            PROG_CONFIRM: begin
                app = is_dig;
                clr = is_clr || is_prog;
                if (is_clr || is_prog) state_d = UNLOCKED;
                if (is_prog && stage_eq) begin
                    code_d     = stage_q;
                    code_len_d = stage_len_q;
                    ok_d       = 1'b1;
                end else if (is_prog) begin
                    err_d = 1'b1;
                end
            end
            LOCKOUT: if (timer_q == '0) begin
                state_d = LOCKED;
                fail_d  = '0;
            end else begin
                timer_d = timer_q - 1'b1;
            end
            default: state_d = LOCKED;
        endcase
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOCKED;
            fail_q      <= '0;
            timer_q     <= '0;
            code_q      <= DEF_CODE;
            code_len_q  <= LEN_W'(DEFAULT_LEN);
            stage_q     <= '0;
            stage_len_q <= '0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fail_q      <= fail_d;
            timer_q     <= timer_d;
            code_q      <= code_d;
            code_len_q  <= code_len_d;
            stage_q     <= stage_d;
            stage_len_q <= stage_len_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
        end
    end

    assign locked    = state_q == LOCKED || state_q == ENTRY || state_q == LOCKOUT;
    assign prog_mode = state_q == PROG_NEW || state_q == PROG_CONFIRM;
    assign lockout   = state_q == LOCKOUT;
    assign ok_pulse  = ok_q;
    assign err_pulse = err_q;
    assign entry_len = len;
    assign state_dbg = state_q;
endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Top-level sequencer for the digital lock. Consumes single-cycle keypad events, collects code digits, compares them against the stored user code, and owns the lock/unlock, reprogram and lockout modes. Sits between the debounced keypad decoder and the LED/actuator drivers, and replaces ad-hoc length checking with one registered controller.

## Interface
- `MIN_LEN`, 4: minimum accepted code length in digits.
- `MAX_LEN`, 6: maximum code length in digits. Also the storage depth.
- `MAX_TRIES`, 3: consecutive failed unlocks that trigger lockout.
- `LOCKOUT_CYC`, 1000: lockout duration in `hwclk` cycles.
- `DEFAULT_LEN`, 4: length of the code loaded at reset. The default code is 1-2-3-4.
- `hwclk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_valid` in 1: one-cycle pulse marking a new key.
- `key_code` in 4: key value, sampled when `key_valid`=1. Values 0-6 are digits, 7 is CLEAR, 8 is PROG, 9 is ENTER, and 10-15 are ignored.
- `locked` out 1: lock engaged.
- `prog_mode` out 1: in PROG_NEW or PROG_CONFIRM.
- `lockout` out 1: in LOCKOUT.
- `ok_pulse` out 1: one cycle, successful unlock or commit.
- `err_pulse` out 1: one cycle, failed compare or rejected length.
- `entry_len` out 3: digits collected in the current entry, saturating at MAX_LEN+1.
- `state_dbg` out 3: current state encoding.

## Operation
- States:
  - LOCKED=0
  - ENTRY=1
  - UNLOCKED=2
  - PROG_NEW=3
  - PROG_CONFIRM=4
  - LOCKOUT=5
- Reset values:
  - State is LOCKED, so `locked`=1.
  - All other outputs are 0.
  - `fail_cnt`=0.
  - Stored code is 1-2-3-4 with length DEFAULT_LEN.
- Digit storage: the entry buffer holds up to MAX_LEN 4-bit digits, first digit in slot 0. A digit beyond MAX_LEN is not stored and sets `ovf`, and `entry_len` saturates.
- LOCKED:
  - A digit clears the buffer, stores the digit, and moves to ENTRY.
  - ENTER, PROG and CLEAR are no-ops.
- ENTRY:
  - A digit appends to the buffer.
  - CLEAR moves to LOCKED, buffer cleared, `fail_cnt` unchanged.
  - PROG is ignored.
  - ENTER performs the compare. A match requires `!ovf`, equal length and all stored digits equal.
  - On a match: go to UNLOCKED, `ok_pulse`, `fail_cnt`=0.
  - On a mismatch: `err_pulse`, `fail_cnt`+1. If the new `fail_cnt`==MAX_TRIES, go to LOCKOUT and load the timer. Otherwise go to LOCKED.
- UNLOCKED:
  - ENTER moves to LOCKED.
  - PROG clears the buffer and moves to PROG_NEW.
  - Digits and CLEAR are ignored.
- PROG_NEW:
  - A digit appends.
  - CLEAR moves to UNLOCKED.
  - PROG checks the length. If MIN_LEN ≤ len ≤ MAX_LEN and `!ovf`, copy the buffer to the staged register, clear the buffer, and move to PROG_CONFIRM. Otherwise `err_pulse` and move to UNLOCKED.
  - ENTER is ignored.
- PROG_CONFIRM:
  - A digit appends.
  - CLEAR moves to UNLOCKED with nothing committed.
  - PROG compares the buffer with the staged register. On a match, commit the staged code and length to storage, `ok_pulse`, and move to UNLOCKED. On a mismatch, `err_pulse`, move to UNLOCKED, and leave the stored code unchanged.
- LOCKOUT:
  - All keys are ignored and the timer decrements every cycle.
  - When the timer reaches 0, move to LOCKED with `fail_cnt`=0.

## Timing
- Event latency: a key accepted in cycle N updates state, `entry_len` and the outputs at edge N+1.
- Pulses: `ok_pulse` and `err_pulse` are high for exactly the one cycle after N, and never both in the same cycle.
- Lockout duration: `lockout` stays high for exactly LOCKOUT_CYC cycles, counted from the edge after the failing ENTER.
- Lockout expiry: a `key_valid` in the same cycle the timer reaches 0 is dropped.
- Back-to-back keys (`key_valid` in consecutive cycles) are each processed. No key is dropped outside LOCKOUT.
- Reset mid-operation (`rst_n` low in any state) immediately forces the reset values. The stored code reverts to the default.
- Compare is combinational on the registered buffer. No multi-cycle compare.

## Structure
- Package `lock_pkg` holds:
  - The state enum.
  - Key constants KEY_CLEAR=7, KEY_PROG=8, KEY_ENTER=9.
  - The digit width (4).
- Sub-module `code_buffer` holds the digit slots, the length counter, the `ovf` flag, clear and append. It is instantiated once for entry. Staged and stored codes are plain registers in the parent.
- Timer width is $clog2(LOCKOUT_CYC+1). `fail_cnt` width is $clog2(MAX_TRIES+1).

## Test plan
- Correct default code: reset, then 1,2,3,4,ENTER → `ok_pulse` at the next edge, `locked`=0, state UNLOCKED.
- Wrong code: 1,2,3,5,ENTER → `err_pulse`, state LOCKED, internal `fail_cnt`=1. A repeat gives 2.
- Lockout: three wrong entries with LOCKOUT_CYC=20 → `lockout`=1 for exactly 20 cycles. Keys sent during lockout have no effect. Afterwards, 1,2,3,4,ENTER unlocks.
- Overflow: 1,2,3,4,5,6,1,ENTER → `entry_len` saturates at 7 and the compare fails.
- Reprogram: unlock, then PROG,6,5,4,3,2,PROG,6,5,4,3,2,PROG → `ok_pulse`. Then ENTER locks, and 6,5,4,3,2,ENTER unlocks while 1,2,3,4 fails.
- Reprogram rejects: unlock, then PROG,1,2,PROG → `err_pulse`, UNLOCKED, code unchanged. Separately, a confirm mismatch gives `err_pulse` with the code unchanged. `rst_n` low during PROG_CONFIRM restores 1-2-3-4.
